mp3_rom_prefetch: RTL and testbench

//  Upstream feeder for the VS1003 SDI shifter: streams the MP3 image from the block ROM as 32-bit words.

---
 rtl/mp3_pkg.sv | 15 +
 rtl/mp3_word_fifo.sv | 51 +++++
 rtl/mp3_rom_prefetch.sv | 134 +++++++++++++
 tb/tb_mp3_rom_prefetch.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
// Shared constants and FSM state type for the MP3 streaming path.
// Imported by the ROM prefetcher, SDI serialiser and play controller.
package mp3_pkg;

   localparam int MP3_ADDR_W    = 17;
   localparam int MP3_DATA_W    = 32;
   localparam int MP3_NUM_WORDS = 103382;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN
   } mp3_state_t;

endpackage

// File: rtl/mp3_word_fifo.sv
// Synchronous word FIFO with occupancy count and a head that is a
// register read, so it holds steady until popped.
module mp3_word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 33
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];
   assign empty     = (count == '0);

endmodule

// File: rtl/mp3_rom_prefetch.sv
// Streams the MP3 image out of block ROM as a valid/ready word stream,
// using read credits so the FIFO never overflows.
module mp3_rom_prefetch
   import mp3_pkg::*;
#(
   parameter int ADDR_W     = MP3_ADDR_W,
   parameter int DATA_W     = MP3_DATA_W,
   parameter int NUM_WORDS  = MP3_NUM_WORDS,
   parameter int FIFO_DEPTH = 4,
   parameter int ROM_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   output logic [DATA_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              word_last,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = $clog2(FIFO_DEPTH + ROM_LAT) + 2;

   mp3_state_t        state;
   mp3_state_t        state_n;
   logic [ADDR_W-1:0] issued_cnt;
   logic [ROM_LAT-1:0] tag_v;
   logic [ROM_LAT-1:0] tag_l;
   logic [CW-1:0]     fifo_cnt;
   logic              fifo_empty;
   logic [DATA_W:0]   head;
   logic [OW-1:0]     occ;
   logic              pop;
   logic              push;
   logic              issue;
   logic              issue_last;
   logic              head_last;
   logic              done_q;

   assign head_last  = head[DATA_W];
   assign word_valid = !fifo_empty;
   assign word_data  = head[DATA_W-1:0];
   assign word_last  = !fifo_empty && head_last;
   assign pop        = word_valid && word_ready;
   assign push       = tag_v[ROM_LAT-1] && !abort;
   assign issue_last = (issued_cnt == ADDR_W'(NUM_WORDS - 1));
   assign rom_addr   = issued_cnt;
   assign busy       = (state != ST_IDLE);
   assign done       = done_q;

   // Committed slots: queued words plus reads in flight, less a pop this edge.
   always_comb begin
      occ = OW'(fifo_cnt);
      for (int i = 0; i < ROM_LAT; i++)
         occ = occ + OW'(tag_v[i]);
      if (pop)
         occ = occ - OW'(1);
   end

   assign issue = (state == ST_FETCH) && !abort &&
                  (issued_cnt < ADDR_W'(NUM_WORDS)) &&
                  (occ < OW'(FIFO_DEPTH));

   always_comb begin
      state_n = state;
      if (abort) begin
         state_n = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:  if (start) state_n = ST_FETCH;
            ST_FETCH: if (issue && issue_last) state_n = ST_DRAIN;
            ST_DRAIN: if (pop && head_last) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst || abort || state_n == ST_IDLE)
         issued_cnt <= '0;
      else if (issue)
         issued_cnt <= issued_cnt + ADDR_W'(1);
   end

   // Tags track reads through the ROM pipe; clearing them drops stale data.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         tag_v <= '0;
         tag_l <= '0;
      end else begin
         tag_v[0] <= issue;
         tag_l[0] <= issue && issue_last;
         for (int i = 1; i < ROM_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_l[i] <= tag_l[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         done_q <= 1'b0;
      else
         done_q <= pop && head_last && !abort;
   end

   mp3_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W + 1)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (abort),
      .push      (push),
      .push_data ({tag_l[ROM_LAT-1], rom_dout}),
      .pop       (pop),
      .head_data (head),
      .count     (fifo_cnt),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_mp3_rom_prefetch.sv
// Drives a 1-cycle and a 3-cycle ROM-latency prefetcher with shared
// stimulus; handshakes are scored against the expected word sequence.
module tb_mp3_rom_prefetch;

   localparam int N  = 10;
   localparam int D  = 4;
   localparam int AW = 17;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst, start, abort, ready;

   logic [AW-1:0] addr1, addr3;
   logic [DW-1:0] dout1, dout3, data1, data3;
   logic valid1, valid3, last1, last3;
   logic busy1, busy3, done1, done3;

   always #5 clk = ~clk;

   mp3_rom_prefetch #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N), .FIFO_DEPTH(D), .ROM_LAT(1)
   ) u_l1 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .rom_addr(addr1), .rom_dout(dout1),
      .word_data(data1), .word_valid(valid1), .word_ready(ready),
      .word_last(last1), .busy(busy1), .done(done1)
   );

   mp3_rom_prefetch #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(N), .FIFO_DEPTH(D), .ROM_LAT(3)
   ) u_l3 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .rom_addr(addr3), .rom_dout(dout3),
      .word_data(data3), .word_valid(valid3), .word_ready(ready),
      .word_last(last3), .busy(busy3), .done(done3)
   );

   // ROM models: data = {15'h0, addr} after the configured latency
   logic [DW-1:0] rom1_q;
   logic [DW-1:0] rom3_q [3];
   always @(posedge clk) begin
      rom1_q    <= {15'h0, addr1};
      rom3_q[0] <= {15'h0, addr3};
      rom3_q[1] <= rom3_q[0];
      rom3_q[2] <= rom3_q[1];
   end
   assign dout1 = rom1_q;
   assign dout3 = rom3_q[2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [32:0] obs1[$], obs3[$];
   int st1[$], st3[$];
   int done_n1 = 0, done_n3 = 0, done_at1 = 0, done_at3 = 0;
   int max1 = 0, max3 = 0, hold_err1 = 0, hold_err3 = 0;
   logic hold1 = 1'b0, hold3 = 1'b0;
   logic [32:0] held1, held3;

   always @(negedge clk) begin
      if (valid1 && ready) begin
         obs1.push_back({last1, data1});
         st1.push_back(cyc);
      end
      if (done1) begin
         done_n1  <= done_n1 + 1;
         done_at1 <= cyc;
      end
      if (int'(u_l1.fifo_cnt) > max1) max1 <= int'(u_l1.fifo_cnt);
      if (hold1 && valid1 && {last1, data1} !== held1)
         hold_err1 <= hold_err1 + 1;
      hold1 <= valid1 && !ready && !rst && !abort;
      held1 <= {last1, data1};
   end

   always @(negedge clk) begin
      if (valid3 && ready) begin
         obs3.push_back({last3, data3});
         st3.push_back(cyc);
      end
      if (done3) begin
         done_n3  <= done_n3 + 1;
         done_at3 <= cyc;
      end
      if (int'(u_l3.fifo_cnt) > max3) max3 <= int'(u_l3.fifo_cnt);
      if (hold3 && valid3 && {last3, data3} !== held3)
         hold_err3 <= hold_err3 + 1;
      hold3 <= valid3 && !ready && !rst && !abort;
      held3 <= {last3, data3};
   end

   int vectors = 0, errors = 0;
   int m1, m3, d1, d3;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic mark();
      m1 = obs1.size();
      m3 = obs3.size();
      d1 = done_n1;
      d3 = done_n3;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while ((done_n1 == d1 || done_n3 == d3) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " done timeout"}, 64'(n < budget), 64'(1));
   endtask

   task automatic check_stream(input string tag);
      logic [32:0] e;
      repeat (3) @(negedge clk);
      chk({tag, " count l1"}, 64'(obs1.size() - m1), 64'(N));
      chk({tag, " count l3"}, 64'(obs3.size() - m3), 64'(N));
      for (int k = 0; k < N; k++) begin
         e = {(k == N - 1), 15'h0, 17'(k)};
         if (m1 + k < obs1.size())
            chk($sformatf("%s l1 w%0d", tag, k), 64'(obs1[m1+k]), 64'(e));
         if (m3 + k < obs3.size())
            chk($sformatf("%s l3 w%0d", tag, k), 64'(obs3[m3+k]), 64'(e));
      end
      chk({tag, " dones l1"}, 64'(done_n1 - d1), 64'(1));
      chk({tag, " dones l3"}, 64'(done_n3 - d3), 64'(1));
      chk({tag, " busy l1"}, 64'(busy1), 64'(0));
      chk({tag, " busy l3"}, 64'(busy3), 64'(0));
      chk({tag, " addr l1"}, 64'(addr1), 64'(0));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " addr l1"}, 64'(addr1), 64'(0));
      chk({tag, " addr l3"}, 64'(addr3), 64'(0));
      chk({tag, " valid l1"}, 64'(valid1), 64'(0));
      chk({tag, " valid l3"}, 64'(valid3), 64'(0));
      chk({tag, " last l1"}, 64'(last1), 64'(0));
      chk({tag, " last l3"}, 64'(last3), 64'(0));
      chk({tag, " busy l1"}, 64'(busy1), 64'(0));
      chk({tag, " busy l3"}, 64'(busy3), 64'(0));
      chk({tag, " done l1"}, 64'(done1), 64'(0));
      chk({tag, " done l3"}, 64'(done3), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc1, acc3, n;
      rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;

      // 1: reset values, first-word latency, full-rate stream
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check_idle("reset");
      tick();
      rst = 1'b0; ready = 1'b1;
      mark();
      pulse_start();
      @(negedge clk);
      chk("t1 busy l1", 64'(busy1), 64'(1));
      chk("t1 busy l3", 64'(busy3), 64'(1));
      chk("t1 addr0 l1", 64'(addr1), 64'(0));
      chk("t1 lat0 l1", 64'(valid1), 64'(0));
      @(negedge clk);
      chk("t1 addr1 l1", 64'(addr1), 64'(1));
      chk("t1 addr1 l3", 64'(addr3), 64'(1));
      chk("t1 lat1 l1", 64'(valid1), 64'(0));
      @(negedge clk);
      chk("t1 lat2 l1", 64'(valid1), 64'(1));
      chk("t1 first l1", 64'(data1), 64'(0));
      chk("t1 lat2 l3", 64'(valid3), 64'(0));
      @(negedge clk);
      chk("t1 lat3 l3", 64'(valid3), 64'(0));
      @(negedge clk);
      chk("t1 lat4 l3", 64'(valid3), 64'(1));
      wait_done("t1", 200);
      check_stream("t1");
      if (obs1.size() >= m1 + N) begin
         chk("t1 rate l1", 64'(st1[m1+N-1] - st1[m1]), 64'(N - 1));
         chk("t1 done at l1", 64'(done_at1), 64'(st1[m1+N-1] + 1));
      end
      if (obs3.size() >= m3 + N)
         chk("t1 done at l3", 64'(done_at3), 64'(st3[m3+N-1] + 1));

      // 2: consumer stalled -> FIFO fills, issue stops at depth
      mark();
      ready = 1'b0;
      pulse_start();
      repeat (20) @(negedge clk);
      chk("t2 addr l1", 64'(addr1), 64'(D));
      chk("t2 addr l3", 64'(addr3), 64'(D));
      chk("t2 head l1", 64'(data1), 64'(0));
      chk("t2 head l3", 64'(data3), 64'(0));
      chk("t2 valid l3", 64'(valid3), 64'(1));
      tick();
      ready = 1'b1;
      wait_done("t2", 200);
      check_stream("t2");

      // 3: random backpressure
      for (int r = 0; r < 3; r++) begin
         mark();
         ready = 1'($urandom_range(0, 1));
         pulse_start();
         n = 0;
         while ((done_n1 == d1 || done_n3 == d3) && n < 400) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            n++;
         end
         chk($sformatf("t3.%0d timeout", r), 64'(n < 400), 64'(1));
         ready = 1'b1;
         check_stream($sformatf("t3.%0d", r));
      end

      // 4: abort with a full FIFO mid-stream, then restart
      mark();
      ready = 1'b0;
      pulse_start();
      repeat (12) tick();
      ready = 1'b1;
      repeat (5) tick();
      ready = 1'b0;
      repeat (12) tick();
      @(negedge clk);
      acc1 = obs1.size() - m1;
      acc3 = obs3.size() - m3;
      chk("t4 full l1", 64'(u_l1.fifo_cnt), 64'(D));
      chk("t4 head l1", 64'(data1), 64'(acc1));
      chk("t4 head l3", 64'(data3), 64'(acc3));
      chk("t4 addr l1", 64'(addr1), 64'(acc1 + D));
      chk("t4 addr l3", 64'(addr3), 64'(acc3 + D));
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk);
      check_idle("t4 abort");
      repeat (6) @(negedge clk);
      check_idle("t4 quiet");
      chk("t4 no done l1", 64'(done_n1), 64'(d1));
      chk("t4 no done l3", 64'(done_n3), 64'(d3));
      tick();
      mark();
      ready = 1'b1;
      pulse_start();
      wait_done("t4r", 200);
      check_stream("t4r");

      // 5: start while busy is ignored; start+abort together stays idle
      mark();
      pulse_start();
      repeat (4) tick();
      pulse_start();
      wait_done("t5", 200);
      check_stream("t5");
      tick();
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check_idle("t5 both");
      repeat (5) @(negedge clk);
      check_idle("t5 both later");

      // 6: reset mid-stream with reads still in the ROM pipe
      tick();
      mark();
      ready = 1'b0;
      pulse_start();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_idle("t6 rst");
      repeat (6) @(negedge clk);
      check_idle("t6 stale");
      tick();
      ready = 1'b1;
      mark();
      pulse_start();
      wait_done("t6r", 200);
      check_stream("t6r");

      chk("max fifo l1", 64'(max1 <= D), 64'(1));
      chk("max fifo l3", 64'(max3 <= D), 64'(1));
      chk("hold l1", 64'(hold_err1), 64'(0));
      chk("hold l3", 64'(hold_err3), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
